adc_sample_dispatch: RTL and testbench

Merges the per-channel sample strobes of the ADC acquisition stage into one tagged sample stream. It consumes the packed 10 × 16-bit data bus and the 10 per-channel ready strobes produced by the LVDS acquisition logic. Each sample is held in a per-channel holding register, and a round-robin arbiter drains the registers into a single valid/ready output port. That port feeds the downstream FIFO and the host transfer path.

---
 rtl/adc_sample_dispatch.sv | 75 +++++++
 tb/tb_adc_sample_dispatch.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/adc_sample_dispatch.sv
// adc_sample_dispatch: per-channel holding registers drained round-robin into one valid/ready sample stream
module adc_sample_dispatch #(
    parameter int NCH = 10,
    parameter int DW  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH*DW-1:0] i_data,
    input  logic [NCH-1:0]    i_rdy,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DW-1:0]     o_data,
    output logic [3:0]        o_chan,
    output logic [NCH-1:0]    o_overflow,
    input  logic              i_ovf_clr
);
    logic [DW-1:0]  hold_q [NCH];
    logic [DW-1:0]  hold_d [NCH];
    logic [NCH-1:0] pend_q, pend_d, ovf_q, ovf_d, gnt;
    logic [3:0]     last_q, last_d, chan_q, chan_d, gnt_idx;
    logic [DW-1:0]  data_q, data_d;
    logic           valid_q, valid_d, load, found, gnt_v;
    int             idx;

    always_comb begin
        load    = !valid_q || i_ready;
        found   = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        // search starts just after the last granted channel and wraps
        for (int i = 1; i <= NCH; i++) begin
            idx = (int'(last_q) + i) % NCH;
            if (!found && pend_q[idx]) begin
                found   = 1'b1;
                gnt_idx = 4'(idx);
            end
        end
        gnt_v = load && found;
        for (int k = 0; k < NCH; k++) begin
            gnt[k]    = gnt_v && (gnt_idx == 4'(k));
            pend_d[k] = i_rdy[k] || (pend_q[k] && !gnt[k]);
            hold_d[k] = (i_rdy[k] && (!pend_q[k] || gnt[k])) ? i_data[k*DW +: DW] : hold_q[k];
            ovf_d[k]  = (i_rdy[k] && pend_q[k] && !gnt[k]) || (ovf_q[k] && !i_ovf_clr);
        end
        valid_d = load ? gnt_v : valid_q;
        data_d  = gnt_v ? hold_q[gnt_idx] : data_q;
        chan_d  = gnt_v ? gnt_idx : chan_q;
        last_d  = gnt_v ? gnt_idx : last_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NCH; k++) hold_q[k] <= '0;
            pend_q  <= '0;
            ovf_q   <= '0;
            last_q  <= 4'(NCH - 1);
            valid_q <= 1'b0;
            data_q  <= '0;
            chan_q  <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) hold_q[k] <= hold_d[k];
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
        end
    end

    assign o_valid    = valid_q;
    assign o_data     = data_q;
    assign o_chan     = chan_q;
    assign o_overflow = ovf_q;
endmodule

// File: tb/tb_adc_sample_dispatch.sv
// tb_adc_sample_dispatch: directed vector table plus hand-written burst, backpressure and reset sequences
module tb_adc_sample_dispatch;
    localparam int NCH = 10;
    localparam int DW  = 16;

    typedef struct {
        logic [NCH-1:0]    rdy;
        logic [NCH*DW-1:0] data;
        logic              ready;
        logic              clr;
        logic              ev;
        logic [3:0]        ec;
        logic [DW-1:0]     ed;
        logic [NCH-1:0]    eo;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH*DW-1:0] i_data;
    logic [NCH-1:0]    i_rdy;
    logic              o_valid;
    logic              i_ready;
    logic [DW-1:0]     o_data;
    logic [3:0]        o_chan;
    logic [NCH-1:0]    o_overflow;
    logic              i_ovf_clr;
    int                n_chk = 0;
    int                n_fail = 0;
    vec_t              tbl [14];
    logic [NCH*DW-1:0] bd;

    adc_sample_dispatch #(.NCH(NCH), .DW(DW)) dut (
        .clk(clk), .rst(rst), .i_data(i_data), .i_rdy(i_rdy), .o_valid(o_valid),
        .i_ready(i_ready), .o_data(o_data), .o_chan(o_chan), .o_overflow(o_overflow),
        .i_ovf_clr(i_ovf_clr)
    );

    always #5 clk = ~clk;

    function automatic vec_t mkv(logic [NCH-1:0] rdy, int ch, logic [DW-1:0] val, logic ready,
                                 logic clr, logic ev, logic [3:0] ec, logic [DW-1:0] ed,
                                 logic [NCH-1:0] eo);
        vec_t v;
        v.rdy = rdy;
        v.data = '0;
        v.data[ch*DW +: DW] = val;
        v.ready = ready;
        v.clr = clr;
        v.ev = ev;
        v.ec = ec;
        v.ed = ed;
        v.eo = eo;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(logic [NCH-1:0] rdy, logic [NCH*DW-1:0] data, logic ready, logic clr);
        i_rdy = rdy;
        i_data = data;
        i_ready = ready;
        i_ovf_clr = clr;
        @(posedge clk);
        #1;
        i_rdy = '0;
        i_ovf_clr = 1'b0;
    endtask

    task automatic expect_out(string tag, logic ev, logic [3:0] ec, logic [DW-1:0] ed, logic [NCH-1:0] eo);
        chk({tag, " valid"}, 32'(o_valid), 32'(ev));
        if (ev) begin
            chk({tag, " chan"}, 32'(o_chan), 32'(ec));
            chk({tag, " data"}, 32'(o_data), 32'(ed));
        end
        chk({tag, " ovf"}, 32'(o_overflow), 32'(eo));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step('0, '0, 1'b1, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        i_data = '0;
        i_rdy = '0;
        i_ready = 1'b1;
        i_ovf_clr = 1'b0;
        for (int k = 0; k < NCH; k++) bd[k*DW +: DW] = 16'h1000 + 16'(k);
        tbl[0]  = mkv(10'h008, 3, 16'hA5A3, 1, 0, 0, 0, 0, 10'h000);
        tbl[1]  = mkv(10'h000, 0, 16'h0000, 1, 0, 1, 3, 16'hA5A3, 10'h000);
        tbl[2]  = mkv(10'h000, 0, 16'h0000, 1, 0, 0, 0, 0, 10'h000);
        tbl[3]  = mkv(10'h001, 0, 16'h0777, 0, 0, 0, 0, 0, 10'h000);
        tbl[4]  = mkv(10'h020, 5, 16'h0001, 0, 0, 1, 0, 16'h0777, 10'h000);
        tbl[5]  = mkv(10'h020, 5, 16'h0002, 0, 0, 1, 0, 16'h0777, 10'h020);
        tbl[6]  = mkv(10'h000, 0, 16'h0000, 1, 0, 1, 5, 16'h0001, 10'h020);
        tbl[7]  = mkv(10'h000, 0, 16'h0000, 1, 0, 0, 0, 0, 10'h020);
        tbl[8]  = mkv(10'h000, 0, 16'h0000, 1, 1, 0, 0, 0, 10'h000);
        tbl[9]  = mkv(10'h000, 0, 16'h0000, 1, 0, 0, 0, 0, 10'h000);
        tbl[10] = mkv(10'h004, 2, 16'h1111, 1, 0, 0, 0, 0, 10'h000);
        tbl[11] = mkv(10'h004, 2, 16'hBEEF, 1, 0, 1, 2, 16'h1111, 10'h000);
        tbl[12] = mkv(10'h000, 0, 16'h0000, 1, 0, 1, 2, 16'hBEEF, 10'h000);
        tbl[13] = mkv(10'h000, 0, 16'h0000, 1, 0, 0, 0, 0, 10'h000);

        step('0, '0, 1'b1, 1'b0);
        step('0, '0, 1'b1, 1'b0);
        chk("reset valid", 32'(o_valid), 32'd0);
        chk("reset data", 32'(o_data), 32'd0);
        chk("reset chan", 32'(o_chan), 32'd0);
        chk("reset ovf", 32'(o_overflow), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].rdy, tbl[i].data, tbl[i].ready, tbl[i].clr);
            expect_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ec, tbl[i].ed, tbl[i].eo);
        end

        do_reset();
        for (int r = 0; r < 2; r++) begin
            step('1, bd, 1'b1, 1'b0);
            expect_out($sformatf("burst%0d strobe", r), 1'b0, 4'd0, 16'd0, '0);
            for (int k = 0; k < NCH; k++) begin
                step('0, '0, 1'b1, 1'b0);
                expect_out($sformatf("burst%0d ch%0d", r, k), 1'b1, 4'(k), 16'h1000 + 16'(k), '0);
            end
            step('0, '0, 1'b1, 1'b0);
            expect_out($sformatf("burst%0d end", r), 1'b0, 4'd0, 16'd0, '0);
        end

        do_reset();
        step('1, bd, 1'b0, 1'b0);
        expect_out("bp strobe", 1'b0, 4'd0, 16'd0, '0);
        for (int c = 0; c < 20; c++) begin
            step('0, '0, 1'b0, 1'b0);
            expect_out($sformatf("bp stall%0d", c), 1'b1, 4'd0, 16'h1000, '0);
        end
        for (int k = 1; k < NCH; k++) begin
            step('0, '0, 1'b1, 1'b0);
            expect_out($sformatf("bp ch%0d", k), 1'b1, 4'(k), 16'h1000 + 16'(k), '0);
        end
        step('0, '0, 1'b1, 1'b0);
        expect_out("bp end", 1'b0, 4'd0, 16'd0, '0);

        do_reset();
        step(10'h01F, bd, 1'b0, 1'b0);
        expect_out("rmid strobe", 1'b0, 4'd0, 16'd0, '0);
        step('0, '0, 1'b0, 1'b0);
        expect_out("rmid grant", 1'b1, 4'd0, 16'h1000, '0);
        step(10'h002, bd, 1'b0, 1'b0);
        expect_out("rmid drop", 1'b1, 4'd0, 16'h1000, 10'h002);
        rst = 1'b1;
        step('0, '0, 1'b1, 1'b0);
        rst = 1'b0;
        chk("rmid valid", 32'(o_valid), 32'd0);
        chk("rmid ovf", 32'(o_overflow), 32'd0);
        chk("rmid data", 32'(o_data), 32'd0);
        chk("rmid chan", 32'(o_chan), 32'd0);
        for (int c = 0; c < 5; c++) begin
            step('0, '0, 1'b1, 1'b0);
            expect_out($sformatf("rmid idle%0d", c), 1'b0, 4'd0, 16'd0, '0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
